// File: rtl/calculator_pkg.sv
// Shared types for the calculator core and its ALU: op codes and ALU FSM states.
package calculator_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_DIV = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ITER = 2'b01,
    DONE = 2'b10
  } alu_state_t;

endpackage

// File: rtl/calculator_alu_if.sv
// ALU request/response channel between the calculator core (master) and the ALU (slave).
interface calculator_alu_if
  import calculator_pkg::*;
#(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] i_alu_input_a;
  logic [DATA_WIDTH-1:0] i_alu_input_b;
  alu_op_t               i_alu_input_op;
  logic                  i_alu_input_signed;
  logic                  i_alu_input_valid;
  logic                  o_alu_input_ready;
  logic [DATA_WIDTH-1:0] o_alu_result;
  logic                  o_alu_error;
  logic                  o_alu_result_valid;
  logic                  i_alu_result_ready;

  modport master (
    output i_alu_input_a, i_alu_input_b, i_alu_input_op, i_alu_input_signed,
    output i_alu_input_valid, i_alu_result_ready,
    input  o_alu_input_ready, o_alu_result, o_alu_error, o_alu_result_valid
  );

  modport slave (
    input  i_alu_input_a, i_alu_input_b, i_alu_input_op, i_alu_input_signed,
    input  i_alu_input_valid, i_alu_result_ready,
    output o_alu_input_ready, o_alu_result, o_alu_error, o_alu_result_valid
  );
endinterface

// File: rtl/calculator_alu_muldiv.sv
// Unsigned magnitude datapath: W-step shift-add multiply and restoring divide.
// product/quotient present the values after the step taken on the current edge,
// so the caller can capture the final answer on the same edge that done is high.
module calculator_alu_muldiv
  import calculator_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    is_div,
  input  logic [DATA_WIDTH-1:0]   mag_a,
  input  logic [DATA_WIDTH-1:0]   mag_b,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] product,
  output logic [DATA_WIDTH-1:0]   quotient
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  logic          busy;
  logic [CW-1:0] count;
  logic          div_mode;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [W-1:0]   rem;
  logic [W-1:0]   quot;
  logic [W-1:0]   divisor;

  logic [2*W-1:0] acc_next;
  logic [W:0]     shifted;
  logic [W+1:0]   trial;
  logic           q_bit;
  logic [W-1:0]   rem_next;
  logic [W-1:0]   quot_next;

  // One multiply step (conditional add) and one restoring-divide step (trial subtract).
  always_comb begin
    acc_next  = acc + (mplier[0] ? mcand : '0);
    shifted   = {rem, quot[W-1]};
    trial     = {1'b0, shifted} - {2'b00, divisor};
    q_bit     = ~trial[W+1];
    rem_next  = q_bit ? trial[W-1:0] : shifted[W-1:0];
    quot_next = {quot[W-2:0], q_bit};
  end

  assign done     = busy && (count == CW'(1));
  assign product  = acc_next;
  assign quotient = quot_next;

  // Iteration registers: load on start, then advance one bit per cycle for W cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      count    <= '0;
      div_mode <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      rem      <= '0;
      quot     <= '0;
      divisor  <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      count    <= CW'(W);
      div_mode <= is_div;
      acc      <= '0;
      mcand    <= {{W{1'b0}}, mag_a};
      mplier   <= mag_b;
      rem      <= '0;
      quot     <= mag_a;
      divisor  <= mag_b;
    end else if (busy) begin
      count <= count - 1'b1;
      if (count == CW'(1)) begin
        busy <= 1'b0;
      end
      if (div_mode) begin
        rem  <= rem_next;
        quot <= quot_next;
      end else begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
    end
  end

endmodule

// File: rtl/calculator_alu.sv
// Calculator ALU: single-outstanding request, ADD/SUB in one cycle, MUL/DIV
// iterated in calculator_alu_muldiv. Sign handling and error flags live here.
module calculator_alu
  import calculator_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input logic             clk,
  input logic             rst_n,
  calculator_alu_if.slave alu
);
  localparam int W = DATA_WIDTH;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_ITER = ITER;
  localparam logic [1:0] S_DONE = DONE;

  // Magnitude of an operand; unsigned operands pass through unchanged.
  function automatic logic [W-1:0] mag_of(input logic [W-1:0] v, input logic is_signed);
    return (is_signed && v[W-1]) ? (~v + 1'b1) : v;
  endfunction

  // Unsigned: carry out. Signed: operands agree in sign but the sum does not.
  function automatic logic add_error(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [W:0] sum, input logic is_signed);
    if (is_signed) return (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
    return sum[W];
  endfunction

  // Unsigned: borrow (a < b). Signed: operands differ in sign and result flips from a.
  function automatic logic sub_error(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [W:0] diff, input logic is_signed);
    if (is_signed) return (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
    return diff[W];
  endfunction

  // Product does not fit in W bits (unsigned) or is not a sign extension of its low half.
  function automatic logic mul_error(input logic [2*W-1:0] p, input logic is_signed);
    if (is_signed) return p[2*W-1:W] != {W{p[W-1]}};
    return |p[2*W-1:W];
  endfunction

  logic [1:0]   state;
  alu_op_t      op_q;
  logic         sgn_q;
  logic         neg_q;
  logic [W-1:0] result_q;
  logic         error_q;

  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  alu_op_t      in_op;
  logic         in_sgn;
  logic         accept;
  logic [W:0]   sum;
  logic [W:0]   diff;
  logic         md_start;
  logic         md_done;
  logic [2*W-1:0] md_product;
  logic [W-1:0]   md_quotient;
  logic [2*W-1:0] prod_final;
  logic [W-1:0]   quot_final;
  logic           div_ovf;

  assign in_a   = alu.i_alu_input_a;
  assign in_b   = alu.i_alu_input_b;
  assign in_op  = alu.i_alu_input_op;
  assign in_sgn = alu.i_alu_input_signed;
  assign accept = alu.i_alu_input_valid && (state == S_IDLE);

  assign sum  = {1'b0, in_a} + {1'b0, in_b};
  assign diff = {1'b0, in_a} - {1'b0, in_b};

  // Divide by zero never enters the iterator; it is answered directly.
  assign md_start = accept && ((in_op == ALU_MUL) || ((in_op == ALU_DIV) && (in_b != '0)));

  calculator_alu_muldiv #(
    .DATA_WIDTH(W)
  ) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (md_start),
    .is_div   (in_op == ALU_DIV),
    .mag_a    (mag_of(in_a, in_sgn)),
    .mag_b    (mag_of(in_b, in_sgn)),
    .done     (md_done),
    .product  (md_product),
    .quotient (md_quotient)
  );

  // Re-apply the result sign; a positive quotient of magnitude 2^(W-1) is the -MIN/-1 overflow.
  always_comb begin
    prod_final = neg_q ? (~md_product + 1'b1) : md_product;
    quot_final = neg_q ? (~md_quotient + 1'b1) : md_quotient;
    div_ovf    = sgn_q && !neg_q && md_quotient[W-1];
  end

  // Control FSM and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= ALU_ADD;
      sgn_q    <= 1'b0;
      neg_q    <= 1'b0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q  <= in_op;
            sgn_q <= in_sgn;
            neg_q <= in_sgn && (in_a[W-1] ^ in_b[W-1]);
            case (in_op)
              ALU_ADD: begin
                result_q <= sum[W-1:0];
                error_q  <= add_error(in_a, in_b, sum, in_sgn);
                state    <= S_DONE;
              end
              ALU_SUB: begin
                result_q <= diff[W-1:0];
                error_q  <= sub_error(in_a, in_b, diff, in_sgn);
                state    <= S_DONE;
              end
              ALU_MUL: begin
                state <= S_ITER;
              end
              default: begin
                if (in_b == '0) begin
                  result_q <= '0;
                  error_q  <= 1'b1;
                  state    <= S_DONE;
                end else begin
                  state <= S_ITER;
                end
              end
            endcase
          end
        end
        S_ITER: begin
          if (md_done) begin
            if (op_q == ALU_MUL) begin
              result_q <= prod_final[W-1:0];
              error_q  <= mul_error(prod_final, sgn_q);
            end else begin
              result_q <= quot_final;
              error_q  <= div_ovf;
            end
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (alu.i_alu_result_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign alu.o_alu_input_ready  = (state == S_IDLE);
  assign alu.o_alu_result_valid = (state == S_DONE);
  assign alu.o_alu_result       = result_q;
  assign alu.o_alu_error        = error_q;

endmodule

// File: tb/tb_calculator_alu.sv
// Scoreboard bench for calculator_alu: directed vectors push expected results,
// an independent monitor checks each presented result, its latency and stability.
module tb_calculator_alu;
  import calculator_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  calculator_alu_if #(.DATA_WIDTH(W)) alu_bus ();

  calculator_alu #(.DATA_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .alu   (alu_bus)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           due;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare every presented result against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (alu_bus.o_alu_result_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%0h required=no_result", alu_bus.o_alu_result);
      end else begin
        if (!seen) check({sb[0].name, "_latency"}, cyc, sb[0].due);
        seen = 1'b1;
        check({sb[0].name, "_result"}, alu_bus.o_alu_result, sb[0].res);
        check({sb[0].name, "_error"}, alu_bus.o_alu_error, sb[0].err);
        check({sb[0].name, "_busy"}, alu_bus.o_alu_input_ready, 0);
        if (alu_bus.i_alu_result_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input string name, input alu_op_t op, input logic sgn,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input logic err, input int lat);
    int n = 0;
    @(negedge clk);
    while (!alu_bus.o_alu_input_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!alu_bus.o_alu_input_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_accept_timeout actual=not_ready required=ready", name);
      return;
    end
    alu_bus.i_alu_input_a      = a;
    alu_bus.i_alu_input_b      = b;
    alu_bus.i_alu_input_op     = op;
    alu_bus.i_alu_input_signed = sgn;
    alu_bus.i_alu_input_valid  = 1'b1;
    @(posedge clk);
    #1;
    alu_bus.i_alu_input_valid  = 1'b0;
    // Scramble operands after the accept edge; they must have no effect.
    alu_bus.i_alu_input_a      = ~a;
    alu_bus.i_alu_input_b      = ~b;
    alu_bus.i_alu_input_signed = ~sgn;
    sb.push_back('{res, err, cyc + lat, name});
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0 pending", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    alu_bus.i_alu_input_a      = '0;
    alu_bus.i_alu_input_b      = '0;
    alu_bus.i_alu_input_op     = ALU_ADD;
    alu_bus.i_alu_input_signed = 1'b0;
    alu_bus.i_alu_input_valid  = 1'b0;
    alu_bus.i_alu_result_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("reset_ready", alu_bus.o_alu_input_ready, 1);
    check("reset_valid", alu_bus.o_alu_result_valid, 0);
    check("reset_result", alu_bus.o_alu_result, 0);
    check("reset_error", alu_bus.o_alu_error, 0);
    rst_n = 1'b1;

    // ADD / SUB
    issue("add_u_carry", ALU_ADD, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 0);
    issue("add_s_ovf",   ALU_ADD, 1'b1, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 0);
    issue("add_u_plain", ALU_ADD, 1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 0);
    issue("sub_s_neg",   ALU_SUB, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 0);
    issue("sub_u_borrow",ALU_SUB, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b1, 0);
    issue("sub_s_ovf",   ALU_SUB, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 0);
    // MUL
    issue("mul_s_neg",   ALU_MUL, 1'b1, 16'hFFFD, 16'h0007, 16'hFFEB, 1'b0, W);
    issue("mul_u_ovf",   ALU_MUL, 1'b0, 16'h0100, 16'h0100, 16'h0000, 1'b1, W);
    issue("mul_s_ovf",   ALU_MUL, 1'b1, 16'hFF00, 16'h0100, 16'h0000, 1'b1, W);
    issue("mul_u_fit",   ALU_MUL, 1'b0, 16'h00FF, 16'h00FF, 16'hFE01, 1'b0, W);
    issue("mul_s_min",   ALU_MUL, 1'b1, 16'h8000, 16'h0001, 16'h8000, 1'b0, W);
    // DIV
    issue("div_u",       ALU_DIV, 1'b0, 16'd100,  16'd7,    16'd14,   1'b0, W);
    issue("div_s_neg_a", ALU_DIV, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 1'b0, W);
    issue("div_s_neg_b", ALU_DIV, 1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 1'b0, W);
    issue("div_u_max",   ALU_DIV, 1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, W);
    issue("div_s_ovf",   ALU_DIV, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 1'b1, W);
    issue("div_u_zero",  ALU_DIV, 1'b0, 16'h1234, 16'h0000, 16'h0000, 1'b1, 0);
    issue("div_s_zero",  ALU_DIV, 1'b1, 16'hFFF9, 16'h0000, 16'h0000, 1'b1, 0);
    drain();

    // Backpressure: result held, new requests ignored while the core stalls.
    @(posedge clk);
    #1 alu_bus.i_alu_result_ready = 1'b0;
    issue("bp_add", ALU_ADD, 1'b0, 16'h1000, 16'h0234, 16'h1234, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      alu_bus.i_alu_input_a     = 16'(i);
      alu_bus.i_alu_input_b     = 16'h0001;
      alu_bus.i_alu_input_op    = ALU_SUB;
      alu_bus.i_alu_input_valid = 1'b1;
      check("bp_ready_low", alu_bus.o_alu_input_ready, 0);
    end
    @(posedge clk);
    #1;
    alu_bus.i_alu_input_valid  = 1'b0;
    alu_bus.i_alu_result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_ready_after", alu_bus.o_alu_input_ready, 1);
    check("bp_valid_after", alu_bus.o_alu_result_valid, 0);
    issue("bp_next_sub", ALU_SUB, 1'b0, 16'h0009, 16'h0004, 16'h0005, 1'b0, 0);
    drain();

    // Asynchronous reset in the middle of a divide.
    issue("rst_div", ALU_DIV, 1'b0, 16'd1000, 16'd3, 16'd333, 1'b0, W);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    check("rst_mid_valid", alu_bus.o_alu_result_valid, 0);
    check("rst_mid_ready", alu_bus.o_alu_input_ready, 1);
    check("rst_mid_result", alu_bus.o_alu_result, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_no_result", alu_bus.o_alu_result_valid, 0);
    issue("mul_after_rst", ALU_MUL, 1'b0, 16'd6, 16'd7, 16'd42, 1'b0, W);
    drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calculator_alu.md
# calculator_alu

Multi-cycle arithmetic unit that serves the calculator core's ALU request/response interface. It accepts one operation at a time: operands A/B, an op code and a signed flag. It computes ADD/SUB in one cycle and MUL/DIV iteratively, one bit per cycle. It returns a W-bit result with an error flag through a valid/ready result channel. It sits between the calculator core and nothing else: the core is the only initiator.

## Interface
- DATA_WIDTH, 16, operand/result width W (≥4)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_alu_input_a  in  W  operand A (dividend / minuend)
- i_alu_input_b  in  W  operand B (divisor / subtrahend)
- i_alu_input_op  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
- i_alu_input_signed  in  1  1: two's complement operands, 0: unsigned
- i_alu_input_valid  in  1  request valid
- o_alu_input_ready  out  1  request accepted when valid&ready
- o_alu_result  out  W  result
- o_alu_error  out  1  overflow / divide-by-zero flag for this result
- o_alu_result_valid  out  1  result valid
- i_alu_result_ready  in  1  core consumes result when valid&ready

## Operation
- States: IDLE, ITER (MUL/DIV loop), DONE. o_alu_input_ready = (state==IDLE); o_alu_result_valid = (state==DONE).
- IDLE: on valid&ready, register a, b, op, signed; ADD/SUB compute and go to DONE; MUL/DIV go to ITER with counter = W, except DIV with b==0 goes straight to DONE.
- ADD/SUB: result = a±b mod 2^W. Unsigned error = carry out (ADD) / borrow (SUB, a<b). Signed error = two's-complement overflow.
- MUL: shift-add on magnitudes (|a|,|b| when signed), 2W-bit product, sign applied at end. Result = low W bits. Error: unsigned, upper W bits ≠ 0; signed, 2W product not the sign extension of its low W bits.
- DIV: restoring division on magnitudes, W iterations. Signed quotient truncates toward zero (sign = sign_a ^ sign_b); remainder discarded. b==0: result 0, error 1. Signed −2^(W−1)/−1: result 0x8000 (W=16), error 1. Otherwise error 0.
- ITER: one bit per cycle, counter decrements; at counter 1 apply sign fix, load result/error, go to DONE.
- DONE: o_alu_result/o_alu_error held stable. On i_alu_result_ready go to IDLE. New requests are not accepted in ITER/DONE; valid is ignored there.
- Input operands are sampled only at the accept edge; later changes have no effect.

## Timing
- Reset (async assert, any state): state IDLE, o_alu_input_ready 1, o_alu_result_valid 0, o_alu_result 0, o_alu_error 0, datapath registers cleared. In-flight op is discarded, no result emitted.
- Accept at edge k. ADD/SUB and DIV-by-zero: result_valid high from k+1. MUL/DIV: result_valid high from k+W+1 (k+17 for W=16).
- Result handshake at edge m: result_valid low and input_ready high from m+1. Minimum issue interval is 2 cycles for ADD/SUB.
- No combinational path from any input to any output. Both outputs are pure functions of state.

## Structure
- Shared package calculator_pkg: alu_op_t enum (ALU_ADD=2'b00, ALU_SUB, ALU_MUL, ALU_DIV) and alu_state_t (IDLE, ITER, DONE). The core uses the same op enum.
- One sub-module is natural: calculator_alu_muldiv. It holds the W-step magnitude shift-add/restoring-divide datapath, with start/done, driven by the FSM in calculator_alu. ADD/SUB, sign handling and error logic stay in the top.

## Test plan
- Unsigned ADD 0xFFFF+0x0001 → result 0x0000, error 1, valid at k+1; signed ADD 0x7FFF+1 → 0x8000, error 1.
- Signed SUB 5−7 → 0xFFFE, error 0; unsigned SUB 5−7 → 0xFFFE, error 1; signed 0x8000−1 → 0x7FFF, error 1.
- Signed MUL −3×7 → 0xFFEB, error 0, valid exactly at k+17; unsigned 0x0100×0x0100 → 0x0000, error 1; signed 0xFF00×0x0100 → 0x0000, error 1.
- DIV: unsigned 100/7 → 14, error 0; signed −7/2 → 0xFFFD; signed 0x8000/0xFFFF → 0x8000, error 1; any /0 → 0, error 1, valid at k+1.
- Backpressure: hold i_alu_result_ready low 5 cycles while driving new valid requests → result/error stable, input_ready 0, no request accepted. Raise ready → input_ready 1 next cycle, next op correct.
- Assert rst_n low at iteration 8 of a DIV → result_valid 0 immediately, input_ready 1. After release, a fresh MUL 6×7 → 42, error 0.
